// File: rtl/ram_scrub_pkg.sv
// Shared types and constants for the RAM scrubber / user-port arbiter.
package ram_scrub_pkg;
  localparam int DW    = 80;
  localparam int AW    = 16;
  localparam int WORDS = 512;
  localparam int IDX_W = $clog2(WORDS);

  localparam logic [DW-1:0]    FULL_MASK = {DW{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, RD, RWAIT, CHK, WB, NEXT} scrub_state_e;

  // Each scrubbed word sits at the base of a 128-address block.
  function automatic logic [AW-1:0] word_addr(input logic [IDX_W-1:0] idx);
    return {idx, {(AW-IDX_W){1'b0}}};
  endfunction
endpackage

// File: rtl/ram_scrub_arbiter_sat_counter.sv
// 16-bit event counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i) begin
    if (clr_i)                     cnt_o <= '0;
    else if (inc_i && cnt_o != '1) cnt_o <= cnt_o + 1'b1;
  end
endmodule

// File: rtl/ram_scrub_arbiter.sv
// Single-port RAM arbiter: user accesses pass straight through, a background
// scrubber reads one word per interval and writes back ECC-corrected data.
module ram_scrub_arbiter
  import ram_scrub_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_scrub_en_i,
  input  logic [15:0]   cfg_interval_i,
  input  logic          usr_req_i,
  input  logic          usr_we_i,
  input  logic [AW-1:0] usr_addr_i,
  input  logic [DW-1:0] usr_wrdata_i,
  input  logic [DW-1:0] usr_bitmask_i,
  output logic          usr_gnt_o,
  output logic          usr_rvalid_o,
  output logic [DW-1:0] usr_rddata_o,
  output logic          ram_cs_o,
  output logic          ram_re_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wrdata_o,
  output logic [DW-1:0] ram_bitmask_o,
  input  logic [DW-1:0] ram_rddata_i,
  input  logic [1:0]    ram_sec_i,
  input  logic [1:0]    ram_ded_i,
  output logic          sweep_done_o,
  output logic [15:0]   corr_cnt_o,
  output logic [15:0]   uncorr_cnt_o
);
  scrub_state_e     state;
  logic [IDX_W-1:0] idx;
  logic [15:0]      wait_cnt;
  logic [1:0]       lat_cnt;
  logic [DW-1:0]    wb_data;
  logic             cancel_q;
  logic [RD_LAT:1]  vld_pipe;

  logic usr_gnt, scrub_rd, scrub_wb, hit_wr, ded_any, sec_any;

  // Nothing reaches the RAM while reset is held, so outputs are quiet at once.
  assign scrub_wb = !rst_i && state == WB;
  assign usr_gnt  = usr_req_i && !rst_i && state != WB;
  assign scrub_rd = !rst_i && state == RD && !usr_req_i;
  assign hit_wr   = usr_gnt && usr_we_i && usr_addr_i[AW-1:AW-IDX_W] == idx;
  assign ded_any  = |ram_ded_i;
  assign sec_any  = |ram_sec_i;

  always_comb begin
    ram_re_o      = (usr_gnt && !usr_we_i) || scrub_rd;
    ram_we_o      = (usr_gnt && usr_we_i) || scrub_wb;
    ram_addr_o    = '0;
    ram_wrdata_o  = '0;
    ram_bitmask_o = '0;
    if (usr_gnt) begin
      ram_addr_o = usr_addr_i;
      if (usr_we_i) begin
        ram_wrdata_o  = usr_wrdata_i;
        ram_bitmask_o = usr_bitmask_i;
      end
    end else if (scrub_rd || scrub_wb) begin
      ram_addr_o = word_addr(idx);
      if (scrub_wb) begin
        ram_wrdata_o  = wb_data;
        ram_bitmask_o = FULL_MASK;
      end
    end
  end

  assign ram_cs_o     = ram_re_o | ram_we_o;
  assign usr_gnt_o    = usr_gnt;
  assign usr_rvalid_o = vld_pipe[RD_LAT];
  assign usr_rddata_o = vld_pipe[RD_LAT] ? ram_rddata_i : '0;
  assign sweep_done_o = !rst_i && state == NEXT && idx == LAST_IDX;

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= usr_gnt && !usr_we_i;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      lat_cnt  <= '0;
      wb_data  <= '0;
      cancel_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cfg_scrub_en_i) begin
          state    <= WAIT;
          wait_cnt <= cfg_interval_i;
        end
        WAIT: begin
          if (!cfg_scrub_en_i)    state    <= IDLE;
          else if (wait_cnt == 0) state    <= RD;
          else                    wait_cnt <= wait_cnt - 16'd1;
        end
        RD: if (!usr_req_i) begin
          cancel_q <= 1'b0;
          lat_cnt  <= 2'(RD_LAT - 1);
          state    <= (RD_LAT == 1) ? CHK : RWAIT;
        end
        RWAIT: begin
          cancel_q <= cancel_q | hit_wr;
          lat_cnt  <= lat_cnt - 2'd1;
          if (lat_cnt <= 2'd1) state <= CHK;
        end
        CHK: begin
          // A user write to the word since the read makes our copy stale.
          if (ded_any) state <= NEXT;
          else if (sec_any && !(cancel_q || hit_wr)) begin
            wb_data <= ram_rddata_i;
            state   <= WB;
          end else state <= NEXT;
        end
        WB: state <= NEXT;
        NEXT: begin
          idx <= idx + 1'b1;
          if (cfg_scrub_en_i) begin
            state    <= WAIT;
            wait_cnt <= cfg_interval_i;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(16)) u_corr_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (state == WB),
    .cnt_o (corr_cnt_o)
  );

  sat_counter #(.W(16)) u_uncorr_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (state == CHK && ded_any),
    .cnt_o (uncorr_cnt_o)
  );
endmodule

// File: tb/tb_ram_scrub_arbiter.sv
// Randomized bench: RAM model plus a transaction-level scoreboard for the arbiter.
module tb_ram_scrub_arbiter;
  localparam int RD_LAT = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_scrub_en_i = 1'b0;
  logic [15:0] cfg_interval_i = '0;
  logic        usr_req_i = 1'b0, usr_we_i = 1'b0;
  logic [15:0] usr_addr_i = '0;
  logic [79:0] usr_wrdata_i = '0, usr_bitmask_i = '0;
  logic        usr_gnt_o, usr_rvalid_o;
  logic [79:0] usr_rddata_o;
  logic        ram_cs_o, ram_re_o, ram_we_o;
  logic [15:0] ram_addr_o;
  logic [79:0] ram_wrdata_o, ram_bitmask_o, ram_rddata_i;
  logic [1:0]  ram_sec_i, ram_ded_i;
  logic        sweep_done_o;
  logic [15:0] corr_cnt_o, uncorr_cnt_o;

  always #5 clk_i = ~clk_i;

  ram_scrub_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_scrub_en_i(cfg_scrub_en_i), .cfg_interval_i(cfg_interval_i),
    .usr_req_i(usr_req_i), .usr_we_i(usr_we_i), .usr_addr_i(usr_addr_i),
    .usr_wrdata_i(usr_wrdata_i), .usr_bitmask_i(usr_bitmask_i),
    .usr_gnt_o(usr_gnt_o), .usr_rvalid_o(usr_rvalid_o), .usr_rddata_o(usr_rddata_o),
    .ram_cs_o(ram_cs_o), .ram_re_o(ram_re_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_wrdata_o(ram_wrdata_o), .ram_bitmask_o(ram_bitmask_o),
    .ram_rddata_i(ram_rddata_i), .ram_sec_i(ram_sec_i), .ram_ded_i(ram_ded_i),
    .sweep_done_o(sweep_done_o), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // RAM contents are a fixed address pattern XOR a delta (bit arrays start at 0).
  bit   [79:0] dmem [65536];
  logic [1:0]  sec_map [512];
  logic [1:0]  ded_map [512];
  logic [79:0] pd  [RD_LAT];
  logic [1:0]  ps  [RD_LAT];
  logic [1:0]  pdd [RD_LAT];

  function automatic logic [79:0] base(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5a5a, ~a ^ 16'h00ff, a};
  endfunction
  function automatic logic [79:0] memrd(input logic [15:0] a);
    return base(a) ^ dmem[a];
  endfunction

  always @(posedge clk_i) begin
    if (ram_we_o)
      dmem[ram_addr_o] <= ((memrd(ram_addr_o) & ~ram_bitmask_o) |
                           (ram_wrdata_o & ram_bitmask_o)) ^ base(ram_addr_o);
    pd[0]  <= ram_re_o ? memrd(ram_addr_o) : '0;
    ps[0]  <= (ram_re_o && ram_addr_o[6:0] == 7'd0) ? sec_map[ram_addr_o[15:7]] : 2'b00;
    pdd[0] <= (ram_re_o && ram_addr_o[6:0] == 7'd0) ? ded_map[ram_addr_o[15:7]] : 2'b00;
    for (int i = 1; i < RD_LAT; i++) begin
      pd[i]  <= pd[i-1];
      ps[i]  <= ps[i-1];
      pdd[i] <= pdd[i-1];
    end
  end
  assign ram_rddata_i = pd[RD_LAT-1];
  assign ram_sec_i    = ps[RD_LAT-1];
  assign ram_ded_i    = pdd[RD_LAT-1];

  // Reference model: scrub order, error outcome per word, user read returns.
  typedef struct { int due; logic [79:0] data; } rexp_t;
  rexp_t rq[$];
  int cyc = 0, exp_idx = 0, m_corr = 0, m_uncorr = 0;
  int n_scrub_rd = 0, n_wb = 0, n_sweeps = 0, last_rd = -1;
  int pend_idx = 0, pend_cyc = 0, wb_cyc = 0;
  bit pend_v = 0, pend_cancel = 0, wb_v = 0, armed = 0, spacing_on = 0, wb_now = 0, exp_rv = 0;
  logic [1:0]  pend_sec, pend_ded;
  logic [79:0] pend_data, wb_data;
  logic [15:0] wb_addr, wb_addr_seen = '0, sa;

  initial forever begin
    @(negedge clk_i);
    cyc++;
    if (rst_i) begin
      chk("rst_cs", ram_cs_o, 0);
      chk("rst_gnt", usr_gnt_o, 0);
      chk("rst_rvalid", usr_rvalid_o, 0);
      chk("rst_sweep", sweep_done_o, 0);
      chk("rst_corr", corr_cnt_o, 0);
      chk("rst_uncorr", uncorr_cnt_o, 0);
      exp_idx = 0; m_corr = 0; m_uncorr = 0; n_scrub_rd = 0; n_wb = 0; n_sweeps = 0;
      last_rd = -1; pend_v = 0; wb_v = 0; armed = 0;
      rq.delete();
    end else begin
      wb_now = wb_v && wb_cyc == cyc;
      chk("corr_cnt", corr_cnt_o, m_corr);
      chk("uncorr_cnt", uncorr_cnt_o, m_uncorr);
      chk("cs", ram_cs_o, ram_re_o | ram_we_o);
      chk("gnt", usr_gnt_o, usr_req_i && !wb_now);
      exp_rv = rq.size() > 0 && rq[0].due == cyc;
      chk("rvalid", usr_rvalid_o, exp_rv);
      if (exp_rv) begin
        chk("rddata", usr_rddata_o, rq[0].data);
        void'(rq.pop_front());
      end else chk("rddata_idle", usr_rddata_o, 0);

      if (usr_gnt_o) begin
        chk("u_re", ram_re_o, !usr_we_i);
        chk("u_we", ram_we_o, usr_we_i);
        chk("u_addr", ram_addr_o, usr_addr_i);
        if (usr_we_i) begin
          chk("u_wdata", ram_wrdata_o, usr_wrdata_i);
          chk("u_mask", ram_bitmask_o, usr_bitmask_i);
          if (pend_v && usr_addr_i[15:7] == 9'(pend_idx)) pend_cancel = 1;
        end else rq.push_back('{cyc + RD_LAT, memrd(usr_addr_i)});
      end else if (wb_now) begin
        chk("wb_we", ram_we_o, 1);
        chk("wb_re", ram_re_o, 0);
        chk("wb_addr", ram_addr_o, wb_addr);
        chk("wb_data", ram_wrdata_o, wb_data);
        chk("wb_mask", ram_bitmask_o, {80{1'b1}});
        wb_addr_seen = ram_addr_o;
        m_corr++; n_wb++; wb_v = 0;
      end else begin
        chk("stray_we", ram_we_o, 0);
        if (ram_re_o) begin
          sa = 16'(exp_idx) << 7;
          chk("scrub_addr", ram_addr_o, sa);
          if (spacing_on && last_rd >= 0) chk("spacing", cyc - last_rd, 7);
          if (exp_idx == 0) chk("sweep_before_wrap", armed, 0);
          pend_v = 1; pend_idx = exp_idx; pend_cyc = cyc; pend_cancel = 0;
          pend_data = memrd(ram_addr_o);
          pend_sec = sec_map[exp_idx]; pend_ded = ded_map[exp_idx];
          if (exp_idx == 511) armed = 1;
          exp_idx = (exp_idx + 1) % 512;
          n_scrub_rd++; last_rd = cyc;
        end
      end

      if (sweep_done_o) begin
        chk("sweep_pulse", armed, 1);
        armed = 0; n_sweeps++;
      end

      if (pend_v && cyc == pend_cyc + RD_LAT) begin
        if (|pend_ded) m_uncorr++;
        else if (|pend_sec && !pend_cancel) begin
          wb_v = 1; wb_cyc = cyc + 1; wb_data = pend_data; wb_addr = 16'(pend_idx) << 7;
        end
        pend_v = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i); #1;
    rst_i = 1'b1; usr_req_i = 1'b0; cfg_scrub_en_i = 1'b0;
    @(negedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic clear_maps();
    for (int i = 0; i < 512; i++) begin sec_map[i] = 2'b00; ded_map[i] = 2'b00; end
  endtask

  task automatic enable(input logic [15:0] ival);
    @(posedge clk_i); #1;
    cfg_interval_i = ival; cfg_scrub_en_i = 1'b1;
  endtask

  task automatic run_until_reads(input int n, input int budget);
    for (int i = 0; i < budget && n_scrub_rd < n; i++) @(negedge clk_i);
  endtask

  initial begin
    clear_maps();
    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b0;

    // Full sweep, interval 3, quiet user port.
    enable(16'd3);
    spacing_on = 1;
    run_until_reads(513, 4000);
    spacing_on = 0;
    chk("sweep_reads", n_scrub_rd, 513);
    chk("sweep_count", n_sweeps, 1);
    chk("sweep_corr", corr_cnt_o, 0);
    chk("sweep_uncorr", uncorr_cnt_o, 0);

    // Single-bit error on idx 5 -> write-back.
    do_reset(); sec_map[5] = 2'b01;
    enable(16'd0);
    run_until_reads(8, 300);
    chk("sec_wb_count", n_wb, 1);
    chk("sec_wb_addr", wb_addr_seen, 16'h0280);
    chk("sec_corr", corr_cnt_o, 1);

    // Double-bit error on idx 5 -> counted, no write.
    do_reset(); clear_maps(); ded_map[5] = 2'b10;
    enable(16'd0);
    run_until_reads(8, 300);
    chk("ded_wb_count", n_wb, 0);
    chk("ded_uncorr", uncorr_cnt_o, 1);
    chk("ded_corr", corr_cnt_o, 0);

    // Single-bit error cancelled by a user write into the same word.
    do_reset(); clear_maps(); sec_map[5] = 2'b01;
    enable(16'd0);
    begin
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk_i);
        seen = ram_re_o && !usr_gnt_o && ram_addr_o == 16'h0280;
      end
      chk("cancel_read_seen", seen, 1);
    end
    @(posedge clk_i); #1;
    usr_req_i = 1; usr_we_i = 1; usr_addr_i = 16'h0285;
    usr_wrdata_i = 80'h1234_5678_9abc_def0_1122; usr_bitmask_i = {80{1'b1}};
    @(posedge clk_i); #1 usr_req_i = 0;
    run_until_reads(9, 300);
    chk("cancel_wb_count", n_wb, 0);
    chk("cancel_corr", corr_cnt_o, 0);

    // User holds the port for 100 cycles: scrubber starves.
    do_reset(); clear_maps();
    enable(16'd2);
    begin
      int rd0;
      rd0 = n_scrub_rd;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk_i); #1;
        usr_req_i = 1;
        usr_we_i = (k != 0);
        usr_addr_i = (k == 0) ? 16'h1234 : {1'b1, 15'($urandom)};
        usr_wrdata_i = {$urandom, $urandom, 16'($urandom)};
        usr_bitmask_i = {$urandom, $urandom, 16'($urandom)};
        @(negedge clk_i);
        chk("hold_gnt", usr_gnt_o, 1);
        if (k == RD_LAT) begin
          chk("hold_rvalid", usr_rvalid_o, 1);
          chk("hold_rdata", usr_rddata_o, memrd(16'h1234));
        end
      end
      chk("hold_no_scrub", n_scrub_rd - rd0, 0);
      @(posedge clk_i); #1 usr_req_i = 0;
    end

    // Random traffic, random error map, enable/interval churn.
    do_reset();
    for (int i = 0; i < 512; i++) begin
      sec_map[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ded_map[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
    enable(16'd1);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i); #1;
      if (c % 50 == 49) cfg_scrub_en_i = ($urandom_range(0, 4) != 0);
      if (c % 64 == 0) cfg_interval_i = 16'($urandom_range(0, 3));
      usr_req_i = ($urandom_range(0, 2) == 0);
      usr_we_i = 1'($urandom);
      usr_addr_i = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                 : {9'(exp_idx + 511 + $urandom_range(0, 1)), 7'($urandom_range(0, 127))};
      usr_wrdata_i = {$urandom, $urandom, 16'($urandom)};
      usr_bitmask_i = {$urandom, $urandom, 16'($urandom)};
    end
    @(posedge clk_i); #1 usr_req_i = 0;
    chk("rand_progress", n_scrub_rd > 20, 1);

    // Reset landing on a write-back cycle.
    do_reset(); clear_maps(); sec_map[2] = 2'b01;
    enable(16'd0);
    begin
      bit seen = 0;
      int busy = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk_i);
        seen = ram_we_o && !usr_gnt_o;
      end
      chk("wbrst_found", seen, 1);
      #1 rst_i = 1; cfg_scrub_en_i = 0;
      @(negedge clk_i);
      chk("wbrst_cs", ram_cs_o, 0);
      chk("wbrst_we", ram_we_o, 0);
      chk("wbrst_re", ram_re_o, 0);
      chk("wbrst_corr", corr_cnt_o, 0);
      #1 rst_i = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_i);
        if (ram_cs_o) busy++;
      end
      chk("wbrst_idle", busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/ram_scrub_arbiter.md
RAM_SCRUB_ARBITER -- requirements
Module: ram_scrub_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: RAM read latency in cycles (1 = no output register, 2 = output register); legal values 1..2.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cfg_scrub_en_i  input  1  scrubber enable.
REQ-005 SHALL have port cfg_interval_i  input  16  idle cycles between scrub reads.
REQ-006 SHALL have port usr_req_i  input  1  user access request.
REQ-007 SHALL have port usr_we_i  input  1  user write (1) / read (0).
REQ-008 SHALL have port usr_addr_i  input  16  user address.
REQ-009 SHALL have port usr_wrdata_i  input  80  user write data.
REQ-010 SHALL have port usr_bitmask_i  input  80  user write bitmask.
REQ-011 SHALL have port usr_gnt_o  output  1  user access accepted this cycle.
REQ-012 SHALL have port usr_rvalid_o  output  1  user read data valid.
REQ-013 SHALL have port usr_rddata_o  output  80  user read data.
REQ-014 SHALL have ports ram_cs_o, ram_re_o, ram_we_o  output  1 each  RAM port controls.
REQ-015 SHALL have port ram_addr_o  output  16  RAM address.
REQ-016 SHALL have ports ram_wrdata_o, ram_bitmask_o  output  80 each  RAM write data/mask.
REQ-017 SHALL have port ram_rddata_i  input  80  RAM read data (ECC-corrected, 80-bit mode).
REQ-018 SHALL have ports ram_sec_i, ram_ded_i  input  2 each  ECC single/double error flags, aligned with ram_rddata_i.
REQ-019 SHALL have port sweep_done_o  output  1  one-cycle pulse per completed 512-word sweep.
REQ-020 SHALL have ports corr_cnt_o, uncorr_cnt_o  output  16 each  corrected / uncorrectable word counts.

Function
REQ-021 SHALL drive ram_cs_o = ram_re_o | ram_we_o; at most one access per cycle.
REQ-022 SHALL assert usr_gnt_o = usr_req_i in every cycle except a scrub write-back (WB) cycle; a granted cycle drives RAM with user fields, re = ~usr_we_i.
REQ-023 SHALL pulse usr_rvalid_o exactly RD_LAT cycles after a granted user read, with usr_rddata_o = ram_rddata_i that cycle (0 otherwise).
REQ-024 SHALL implement FSM IDLE, WAIT, RD, RWAIT, CHK, WB, NEXT; IDLE->WAIT when cfg_scrub_en_i=1.
REQ-025 WAIT SHALL load a 16-bit counter with cfg_interval_i on entry, decrement per cycle, go to RD at 0 (interval 0 -> RD next cycle).
REQ-026 RD SHALL issue a read at {idx[8:0],7'd0} only in a cycle with usr_req_i=0, else hold in RD (user priority).
REQ-027 RWAIT SHALL last RD_LAT-1 cycles; CHK samples ram_rddata_i/flags RD_LAT cycles after the scrub read.
REQ-028 CHK: any ram_ded_i bit -> uncorr_cnt+1, NEXT; else any ram_sec_i bit -> capture data, WB; else NEXT.
REQ-029 WB SHALL write captured data at the same address with bitmask all-ones, blocking user that cycle, then corr_cnt+1, NEXT.
REQ-030 A granted user write with usr_addr_i[15:7]==idx during RD-issue through CHK SHALL cancel that word's write-back (no WB, no count).
REQ-031 NEXT SHALL increment idx modulo 512; on 511->0 pulse sweep_done_o; go to WAIT if enabled, else IDLE (idx retained).
REQ-032 Deasserting cfg_scrub_en_i SHALL take effect only at NEXT or in WAIT (WAIT->IDLE immediately).
REQ-033 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-034 rst_i SHALL force state IDLE, idx 0, counters 0, all outputs 0 on the next edge, including mid-WB or mid-read; in-flight user rvalid is dropped.

Structure
REQ-035 Shared package ram_scrub_pkg SHALL hold the FSM state typedef, FULL_MASK (80 ones) and WORDS=512.
REQ-036 Counters SHALL use one sub-module sat_counter (16-bit, saturating increment, sync clear), instanced twice.

Verification
REQ-037 RD_LAT=1, interval 3, no errors, no user traffic -> scrub reads at 0x0000,0x0080,... every 7 cycles; sweep_done_o once after 512 reads; counters 0.
REQ-038 ram_sec_i=2'b01 on read of idx 5 -> write at 0x0280, wrdata = sampled data, mask all-ones; corr_cnt_o=1.
REQ-039 ram_ded_i=2'b10 on read of idx 5 -> no write; uncorr_cnt_o=1.
REQ-040 usr_req_i held high 100 cycles -> no scrub access, usr_gnt_o=1 throughout; user read at 0x1234 gives usr_rvalid_o exactly RD_LAT cycles later.
REQ-041 Sec on idx 5 plus granted user write to 0x0285 before CHK -> write-back cancelled, corr_cnt_o=0.
REQ-042 rst_i asserted in WB cycle -> next cycle all RAM controls 0, counters 0, state IDLE.
